lieat_ifu_pcgen: RTL and testbench

LIEAT_IFU_PCGEN -- requirements
Module: lieat_ifu_pcgen

---
 rtl/lieat_ifu_pcgen.sv | 145 ++++++++++++++
 tb/tb_lieat_ifu_pcgen.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lieat_ifu_pcgen.sv
// lieat_ifu_pcgen: fetch PC generator for the IFU.
// Issues one instruction fetch at a time, holds the returned word for the
// mini-decoder, computes the statically predicted next PC and hands the
// instruction to the IDU. EXU flushes redirect the PC from any state.
module lieat_ifu_pcgen #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic            clk,
  input  logic            rst_n,

  output logic            ifu_req_valid,
  input  logic            ifu_req_ready,
  output logic [XLEN-1:0] ifu_req_pc,

  input  logic            ifu_rsp_valid,
  input  logic [XLEN-1:0] ifu_rsp_inst,

  output logic [XLEN-1:0] pcgen_inst,
  input  logic            dec_bxx,
  input  logic            dec_jal,
  input  logic            dec_rs1en,
  input  logic            dec_fencei,
  input  logic [XLEN-1:0] dec_immb,
  input  logic [XLEN-1:0] jalr_rs1_val,
  input  logic            jalr_rs1_rdy,

  output logic            ifu_o_valid,
  input  logic            ifu_o_ready,
  output logic [XLEN-1:0] ifu_o_pc,
  output logic [XLEN-1:0] ifu_o_inst,
  output logic            ifu_o_pred_taken,

  input  logic            exu_flush,
  input  logic [XLEN-1:0] exu_flush_pc
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_OUT   = 2'd2,
    S_FWAIT = 2'd3
  } state_e;

  state_e          state_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] inst_q;
  logic            discard_q;

  logic [XLEN-1:0] next_pc;
  logic [XLEN-1:0] jalr_sum;
  logic            req_hs;
  logic            out_fire;
  logic            rs1_stall;
  logic            in_out;

  assign in_out    = (state_q == S_OUT);
  assign rs1_stall = dec_rs1en & ~jalr_rs1_rdy;
  assign jalr_sum  = jalr_rs1_val + dec_immb;

  assign ifu_req_valid    = (state_q == S_REQ);
  assign ifu_req_pc       = pc_q;
  assign req_hs           = ifu_req_valid & ifu_req_ready;

  assign pcgen_inst       = inst_q;
  assign ifu_o_pc         = pc_q;
  assign ifu_o_inst       = inst_q;
  assign ifu_o_valid      = in_out & ~rs1_stall & ~exu_flush;
  assign out_fire         = ifu_o_valid & ifu_o_ready;
  assign ifu_o_pred_taken = in_out & (dec_jal | dec_rs1en | (dec_bxx & dec_immb[XLEN-1]));

  // Static prediction: jumps always taken, backward branches taken, else fall through.
  always_comb begin
    next_pc = pc_q + XLEN'(4);
    if (dec_jal) begin
      next_pc = pc_q + dec_immb;
    end else if (dec_rs1en) begin
      next_pc = {jalr_sum[XLEN-1:1], 1'b0};
    end else if (dec_bxx && dec_immb[XLEN-1]) begin
      next_pc = pc_q + dec_immb;
    end
  end

  // Fetch control FSM; a flush always wins and leaves a discard mark if a response is still owed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_REQ;
      pc_q      <= RESET_PC;
      inst_q    <= '0;
      discard_q <= 1'b0;
    end else begin
      case (state_q)
        S_REQ: begin
          if (exu_flush) begin
            pc_q <= exu_flush_pc;
            if (req_hs) begin
              discard_q <= 1'b1;
              state_q   <= S_WAIT;
            end
          end else if (req_hs) begin
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (exu_flush) begin
            pc_q <= exu_flush_pc;
            if (ifu_rsp_valid) begin
              discard_q <= 1'b0;
              state_q   <= S_REQ;
            end else begin
              discard_q <= 1'b1;
            end
          end else if (ifu_rsp_valid) begin
            if (discard_q) begin
              discard_q <= 1'b0;
              state_q   <= S_REQ;
            end else begin
              inst_q  <= ifu_rsp_inst;
              state_q <= S_OUT;
            end
          end
        end
        S_OUT: begin
          if (exu_flush) begin
            pc_q    <= exu_flush_pc;
            state_q <= S_REQ;
          end else if (out_fire) begin
            pc_q    <= next_pc;
            state_q <= dec_fencei ? S_FWAIT : S_REQ;
          end
        end
        S_FWAIT: begin
          if (exu_flush) begin
            pc_q    <= exu_flush_pc;
            state_q <= S_REQ;
          end
        end
        default: begin
          state_q <= S_REQ;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lieat_ifu_pcgen.sv
// tb_lieat_ifu_pcgen: directed scenarios followed by randomized traffic,
// compared every cycle against a transaction-level model of the fetch unit.
module tb_lieat_ifu_pcgen;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic        clk;
  logic        rst_n;
  logic        ifu_req_valid;
  logic        ifu_req_ready;
  logic [31:0] ifu_req_pc;
  logic        ifu_rsp_valid;
  logic [31:0] ifu_rsp_inst;
  logic [31:0] pcgen_inst;
  logic        dec_bxx;
  logic        dec_jal;
  logic        dec_rs1en;
  logic        dec_fencei;
  logic [31:0] dec_immb;
  logic [31:0] jalr_rs1_val;
  logic        jalr_rs1_rdy;
  logic        ifu_o_valid;
  logic        ifu_o_ready;
  logic [31:0] ifu_o_pc;
  logic [31:0] ifu_o_inst;
  logic        ifu_o_pred_taken;
  logic        exu_flush;
  logic [31:0] exu_flush_pc;

  lieat_ifu_pcgen #(.XLEN(32), .RESET_PC(RESET_PC)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .ifu_req_valid    (ifu_req_valid),
    .ifu_req_ready    (ifu_req_ready),
    .ifu_req_pc       (ifu_req_pc),
    .ifu_rsp_valid    (ifu_rsp_valid),
    .ifu_rsp_inst     (ifu_rsp_inst),
    .pcgen_inst       (pcgen_inst),
    .dec_bxx          (dec_bxx),
    .dec_jal          (dec_jal),
    .dec_rs1en        (dec_rs1en),
    .dec_fencei       (dec_fencei),
    .dec_immb         (dec_immb),
    .jalr_rs1_val     (jalr_rs1_val),
    .jalr_rs1_rdy     (jalr_rs1_rdy),
    .ifu_o_valid      (ifu_o_valid),
    .ifu_o_ready      (ifu_o_ready),
    .ifu_o_pc         (ifu_o_pc),
    .ifu_o_inst       (ifu_o_inst),
    .ifu_o_pred_taken (ifu_o_pred_taken),
    .exu_flush        (exu_flush),
    .exu_flush_pc     (exu_flush_pc)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int bad;

  // Stimulus knobs; class codes: 0 alu, 1 jal, 2 jalr, 3 branch, 4 fence.i
  bit          randomMode;
  logic        reqReadyV, oReadyV, rs1RdyV, flushV;
  logic [31:0] flushPcV;
  int          memLatV;
  int          dirClass;
  logic [31:0] dirImm, dirRs1;

  // Memory: serves the single outstanding request after a countdown.
  bit          memBusy;
  int          memCnt;
  logic [31:0] memInst, memImm, memRs1;
  int          memClass;

  // Reference model state.
  logic [31:0] mPc, mInst, hImm, hRs1;
  int          hClass;
  bit          mPending, mDiscard, mHeld, mFence;

  // Values observed in the most recent cycle.
  logic        obsReqValid, obsOValid, obsPred;
  logic [31:0] obsReqPc, obsOPc, obsOInst;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h want=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] modelNextPc();
    case (hClass)
      1:       return mPc + hImm;
      2:       return (hRs1 + hImm) & ~32'h1;
      3:       return hImm[31] ? (mPc + hImm) : (mPc + 32'd4);
      default: return mPc + 32'd4;
    endcase
  endfunction

  task automatic resetModel();
    mPc = RESET_PC; mInst = '0; hImm = '0; hRs1 = '0; hClass = 0;
    mPending = 0; mDiscard = 0; mHeld = 0; mFence = 0;
  endtask

  task automatic doReset(input bit keepMem);
    @(negedge clk);
    rst_n = 1'b0;
    reqReadyV = 1'b0; flushV = 1'b0; oReadyV = 1'b1; rs1RdyV = 1'b1;
    ifu_req_ready = 1'b0; ifu_rsp_valid = 1'b0; exu_flush = 1'b0;
    ifu_o_ready = 1'b1; jalr_rs1_rdy = 1'b1;
    dec_jal = 0; dec_rs1en = 0; dec_bxx = 0; dec_fencei = 0;
    resetModel();
    if (!keepMem) memBusy = 0;
    #1;
    checkOutput("rstOValid", ifu_o_valid, 1'b0);
    checkOutput("rstPred", ifu_o_pred_taken, 1'b0);
    checkOutput("rstInst", pcgen_inst, 32'h0);
    checkOutput("rstReqValid", ifu_req_valid, 1'b1);
    checkOutput("rstReqPc", ifu_req_pc, RESET_PC);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock cycle: drive inputs, compare outputs with the model, advance model and memory.
  task automatic applyStimulus();
    logic        rspV, expReqV, expOV, expPred, hs, fire;
    @(negedge clk);
    rspV = 1'b0;
    if (memBusy) begin
      memCnt--;
      if (memCnt == 0) begin
        rspV = 1'b1;
        memBusy = 0;
      end
    end
    if (randomMode) begin
      reqReadyV = ($urandom_range(0, 9) < 6);
      oReadyV   = ($urandom_range(0, 9) < 7);
      rs1RdyV   = ($urandom_range(0, 3) != 0);
      flushV    = ($urandom_range(0, 19) == 0);
      flushPcV  = $urandom & ~32'h3;
    end
    ifu_req_ready = reqReadyV;
    ifu_rsp_valid = rspV;
    ifu_rsp_inst  = memInst;
    exu_flush     = flushV;
    exu_flush_pc  = flushPcV;
    jalr_rs1_rdy  = rs1RdyV;
    ifu_o_ready   = oReadyV;
    dec_jal       = (hClass == 1);
    dec_rs1en     = (hClass == 2);
    dec_bxx       = (hClass == 3);
    dec_fencei    = (hClass == 4);
    dec_immb      = hImm;
    jalr_rs1_val  = hRs1;
    #1;
    obsReqValid = ifu_req_valid; obsReqPc = ifu_req_pc;
    obsOValid = ifu_o_valid; obsOPc = ifu_o_pc; obsOInst = ifu_o_inst; obsPred = ifu_o_pred_taken;

    expReqV = !mPending && !mHeld && !mFence;
    expOV   = mHeld && !(hClass == 2 && !rs1RdyV) && !flushV;
    expPred = mHeld && (hClass == 1 || hClass == 2 || (hClass == 3 && hImm[31]));
    checkOutput("reqValid", obsReqValid, expReqV);
    if (expReqV) checkOutput("reqPc", obsReqPc, mPc);
    checkOutput("oValid", obsOValid, expOV);
    checkOutput("predTaken", obsPred, expPred);
    checkOutput("heldInst", pcgen_inst, mInst);
    if (mHeld) begin
      checkOutput("oPc", obsOPc, mPc);
      checkOutput("oInst", obsOInst, mInst);
    end

    hs   = expReqV && reqReadyV;
    fire = expOV && oReadyV;
    if (flushV) begin
      if (expReqV) begin
        if (reqReadyV) begin mPending = 1; mDiscard = 1; end
      end else if (mPending) begin
        if (rspV) begin mPending = 0; mDiscard = 0; end
        else mDiscard = 1;
      end
      mHeld = 0; mFence = 0; mPc = flushPcV;
    end else if (expReqV) begin
      if (reqReadyV) mPending = 1;
    end else if (mPending) begin
      if (rspV) begin
        mPending = 0;
        if (mDiscard) mDiscard = 0;
        else begin
          mHeld = 1; mInst = memInst; hClass = memClass; hImm = memImm; hRs1 = memRs1;
        end
      end
    end else if (mHeld && fire) begin
      mPc = modelNextPc();
      mHeld = 0;
      mFence = (hClass == 4);
    end

    if (hs) begin
      memBusy = 1;
      memCnt  = randomMode ? int'($urandom_range(1, 3)) : memLatV;
      memInst = $urandom;
      if (randomMode) begin
        memClass = int'($urandom_range(0, 4));
        memImm   = (32'($urandom_range(0, 511)) - 32'd256) << 2;
        memRs1   = $urandom;
      end else begin
        memClass = dirClass; memImm = dirImm; memRs1 = dirRs1;
      end
    end
  endtask

  // Fetch one instruction with single-cycle memory latency and an accepting IDU.
  task automatic fetchOne(input int cls, input logic [31:0] imm, input logic [31:0] rs1,
                          output logic [31:0] reqPc, output logic pred);
    dirClass = cls; dirImm = imm; dirRs1 = rs1; memLatV = 1;
    reqReadyV = 1; oReadyV = 1; rs1RdyV = 1; flushV = 0;
    applyStimulus();
    reqPc = obsReqPc;
    reqReadyV = 0;
    applyStimulus();
    applyStimulus();
    pred = obsPred;
  endtask

  task automatic flushTo(input logic [31:0] pc);
    reqReadyV = 0; flushV = 1; flushPcV = pc;
    applyStimulus();
    flushV = 0;
  endtask

  logic [31:0] rp;
  logic        pt;

  initial begin
    total = 0; bad = 0; randomMode = 0;
    rst_n = 1'b0;
    reqReadyV = 0; oReadyV = 1; rs1RdyV = 1; flushV = 0; flushPcV = '0;
    memLatV = 1; dirClass = 0; dirImm = '0; dirRs1 = '0;
    memBusy = 0; memCnt = 0; memInst = '0; memClass = 0; memImm = '0; memRs1 = '0;
    ifu_rsp_inst = '0; dec_immb = '0; jalr_rs1_val = '0; exu_flush_pc = '0;
    resetModel();
    doReset(0);

    fetchOne(0, 32'h0, 32'h0, rp, pt);
    checkOutput("seqReq0", rp, 32'h8000_0000);
    checkOutput("seqPred0", pt, 1'b0);
    fetchOne(0, 32'h0, 32'h0, rp, pt);
    checkOutput("seqReq1", rp, 32'h8000_0004);

    doReset(0);
    fetchOne(1, 32'h100, 32'h0, rp, pt);
    checkOutput("jalPred", pt, 1'b1);
    fetchOne(0, 32'h0, 32'h0, rp, pt);
    checkOutput("jalTarget", rp, 32'h8000_0100);
    flushTo(32'h8000_0010);
    fetchOne(3, 32'hFFFF_FFF8, 32'h0, rp, pt);
    checkOutput("bwdPred", pt, 1'b1);
    fetchOne(0, 32'h0, 32'h0, rp, pt);
    checkOutput("bwdTarget", rp, 32'h8000_0008);
    flushTo(32'h8000_0010);
    fetchOne(3, 32'h8, 32'h0, rp, pt);
    checkOutput("fwdPred", pt, 1'b0);
    fetchOne(0, 32'h0, 32'h0, rp, pt);
    checkOutput("fwdTarget", rp, 32'h8000_0014);

    dirClass = 2; dirImm = 32'h0; dirRs1 = 32'h8000_1003; memLatV = 1;
    reqReadyV = 1; applyStimulus();
    reqReadyV = 0; applyStimulus();
    rs1RdyV = 0;
    repeat (3) begin
      applyStimulus();
      checkOutput("jalrStall", obsOValid, 1'b0);
    end
    rs1RdyV = 1; applyStimulus();
    checkOutput("jalrFire", obsOValid, 1'b1);
    applyStimulus();
    checkOutput("jalrTarget", obsReqPc, 32'h8000_1002);

    dirClass = 0; memLatV = 3;
    reqReadyV = 1; applyStimulus();
    reqReadyV = 0; flushV = 1; flushPcV = 32'h8000_2000; applyStimulus();
    flushV = 0;
    repeat (2) begin
      applyStimulus();
      checkOutput("dropValid", obsOValid, 1'b0);
    end
    applyStimulus();
    checkOutput("flushReqValid", obsReqValid, 1'b1);
    checkOutput("flushReqPc", obsReqPc, 32'h8000_2000);

    fetchOne(4, 32'h0, 32'h0, rp, pt);
    reqReadyV = 1;
    repeat (10) begin
      applyStimulus();
      checkOutput("fenceNoReq", obsReqValid, 1'b0);
    end
    reqReadyV = 0; flushV = 1; flushPcV = 32'h8000_0004; applyStimulus();
    flushV = 0; applyStimulus();
    checkOutput("fenceResumeValid", obsReqValid, 1'b1);
    checkOutput("fenceResumePc", obsReqPc, 32'h8000_0004);

    dirClass = 0; memLatV = 1;
    reqReadyV = 1; applyStimulus();
    reqReadyV = 0; applyStimulus();
    oReadyV = 0;
    repeat (5) begin
      applyStimulus();
      checkOutput("holdValid", obsOValid, 1'b1);
      checkOutput("holdPc", obsOPc, 32'h8000_0004);
      checkOutput("holdInst", obsOInst, memInst);
      checkOutput("holdNoReq", obsReqValid, 1'b0);
    end
    oReadyV = 1; applyStimulus();

    dirClass = 0; memLatV = 3;
    reqReadyV = 1; applyStimulus();
    doReset(1);
    repeat (3) begin
      applyStimulus();
      checkOutput("lateRspValid", obsOValid, 1'b0);
    end
    applyStimulus();
    checkOutput("lateRspReqPc", obsReqPc, RESET_PC);

    doReset(0);
    randomMode = 1;
    repeat (3000) applyStimulus();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
